// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter for two masters sharing the multiplexed address/data memory bus.
// Runs one complete external cycle per grant; all pins are Moore-decoded from registered state.
module sysbus_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic [1:0]    Req,
    input  logic [1:0]    Write,
    input  logic [AW-1:0] Addr0,
    input  logic [AW-1:0] Addr1,
    input  logic [DW-1:0] WData0,
    input  logic [DW-1:0] WData1,
    output logic [1:0]    Grant,
    output logic [1:0]    Ack,
    output logic [DW-1:0] RData,
    output logic [DW-1:0] BusOut,
    output logic          BusDrive,
    input  logic [DW-1:0] BusIn,
    output logic          ALE,
    output logic          nME,
    output logic          nOE,
    output logic          nWE
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic [2:0]    state;
    logic [1:0]    grant_q;
    logic          last_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdat_q;
    logic [DW-1:0] rdata_q;
    logic [3:0]    wait_cnt;
    logic          pick;

    // On a tie the requester not served last wins; otherwise whoever is asking.
    always_comb begin
        pick = 1'b0;
        if (Req == 2'b11)
            pick = ~last_q;
        else
            pick = Req[1];
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= S_IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            rdata_q  <= '0;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|Req) begin
                        state   <= S_ADDR;
                        grant_q <= pick ? 2'b10 : 2'b01;
                        wr_q    <= Write[pick];
                        addr_q  <= pick ? Addr1 : Addr0;
                        wdat_q  <= pick ? WData1 : WData0;
                    end
                end
                S_ADDR: begin
                    if (WAIT_STATES > 0) begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= S_DATA;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                S_DATA: begin
                    if (!wr_q)
                        rdata_q <= BusIn;
                    state <= S_DONE;
                end
                S_DONE: begin
                    last_q  <= grant_q[1];
                    grant_q <= 2'b00;
                    state   <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    // DONE leaves the bus undriven so the memory can turn it around before the next address.
    always_comb begin
        Ack      = 2'b00;
        BusOut   = '0;
        BusDrive = 1'b0;
        ALE      = 1'b0;
        nME      = 1'b1;
        nOE      = 1'b1;
        nWE      = 1'b1;
        case (state)
            S_ADDR: begin
                ALE      = 1'b1;
                nME      = 1'b0;
                BusDrive = 1'b1;
                BusOut   = addr_q;
            end
            S_WAIT, S_DATA: begin
                nME = 1'b0;
                if (wr_q) begin
                    BusDrive = 1'b1;
                    BusOut   = wdat_q;
                    nWE      = 1'b0;
                end else begin
                    nOE = 1'b0;
                end
            end
            S_DONE: begin
                Ack = grant_q;
            end
            default: ;
        endcase
    end

    assign Grant = grant_q;
    assign RData = rdata_q;

endmodule
